// File: rtl/param_multiplier_if.sv
// param_multiplier_if: operand, memory and readback signals of param_multiplier
interface param_multiplier_if #(
  parameter int IN_WIDTH = 16,
  parameter int DEPTH = 64
);
  localparam int OUT_WIDTH = 2 * IN_WIDTH;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic EN_mult;
  logic RDY_mult;
  logic [IN_WIDTH-1:0] mult_input0;
  logic [IN_WIDTH-1:0] mult_input1;
  logic EN_blockRead;
  logic EN_writeMem;
  logic [ADDR_WIDTH-1:0] writeMem_addr;
  logic [OUT_WIDTH-1:0] writeMem_val;
  logic EN_readMem;
  logic [ADDR_WIDTH-1:0] readMem_addr;
  logic [OUT_WIDTH-1:0] readMem_val;
  logic VALID_memVal;
  logic [OUT_WIDTH-1:0] memVal_data;
  modport slave (
    input EN_mult, mult_input0, mult_input1, EN_blockRead, readMem_val,
    output RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr,
    VALID_memVal, memVal_data
  );
  modport master (
    output EN_mult, mult_input0, mult_input1, EN_blockRead, readMem_val,
    input RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr,
    VALID_memVal, memVal_data
  );
endinterface

// File: rtl/param_multiplier.sv
// param_multiplier: block multiplier storing products in external memory, then streaming them back.
// Optional MULT_ACCUM_EN adds mode_accum for running-sum entries.
module param_multiplier #(
  parameter int IN_WIDTH = 16,
  parameter int DEPTH = 64
) (
  input logic CLK,
  input logic rst,
`ifdef MULT_ACCUM_EN
  input logic mode_accum,
`endif
  param_multiplier_if.slave m
);
  localparam int OUT_WIDTH = 2 * IN_WIDTH;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [2:0] {IDLE, FILL, FULL, READ, DRAIN} state_t;
  state_t st;
  logic [CW-1:0] idx, cnt;
  logic pend, acc;
  logic [OUT_WIDTH-1:0] prod, wval;
  assign prod = OUT_WIDTH'(m.mult_input0) * OUT_WIDTH'(m.mult_input1);
  assign m.RDY_mult = !rst && (st == IDLE || st == FILL);
  assign acc = m.EN_mult && m.RDY_mult;
  assign m.memVal_data = m.VALID_memVal ? m.readMem_val : '0;
`ifdef MULT_ACCUM_EN
  logic am;
  always_ff @(posedge CLK)
    if (rst) am <= 1'b0;
    else if (acc && st == IDLE) am <= mode_accum;
  // the last written value is the running sum of the block so far
  assign wval = (st == FILL && am) ? m.writeMem_val + prod : prod;
`else
  assign wval = prod;
`endif
  always_ff @(posedge CLK) begin
    if (rst) begin
      st <= IDLE;
      idx <= '0;
      cnt <= '0;
      pend <= 1'b0;
      m.EN_writeMem <= 1'b0;
      m.writeMem_addr <= '0;
      m.writeMem_val <= '0;
      m.EN_readMem <= 1'b0;
      m.readMem_addr <= '0;
      m.VALID_memVal <= 1'b0;
    end else begin
      m.EN_writeMem <= acc;
      m.VALID_memVal <= m.EN_readMem;
      if (acc) begin
        m.writeMem_addr <= idx[ADDR_WIDTH-1:0];
        m.writeMem_val <= wval;
        idx <= idx + CW'(1);
      end
      case (st)
        IDLE: if (acc) st <= FILL;
        FILL:
          if ((acc && idx == CW'(DEPTH - 1)) || m.EN_blockRead) begin
            st <= FULL;
            cnt <= idx + CW'(acc);
            pend <= m.EN_blockRead;
          end
        // entering READ here puts the first read after the final write cycle
        FULL:
          if (pend || m.EN_blockRead) begin
            st <= READ;
            pend <= 1'b0;
            m.EN_readMem <= 1'b1;
            m.readMem_addr <= '0;
          end
        READ:
          if (CW'(m.readMem_addr) == cnt - CW'(1)) begin
            m.EN_readMem <= 1'b0;
            st <= DRAIN;
          end else m.readMem_addr <= m.readMem_addr + ADDR_WIDTH'(1);
        DRAIN: begin
          st <= IDLE;
          idx <= '0;
          cnt <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_multiplier.sv
// tb_param_multiplier: directed scoreboard bench with behavioural 1-cycle-latency memories.
module tb_param_multiplier;
  logic clk = 1'b0, rst = 1'b1, rst_q = 1'b1;
  logic mode_a = 1'b0, mode_b = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_q <= rst;
  param_multiplier_if #(.IN_WIDTH(16), .DEPTH(64)) a ();
  param_multiplier_if #(.IN_WIDTH(8), .DEPTH(4)) b ();
  param_multiplier #(.IN_WIDTH(16), .DEPTH(64)) dut_a (
    .CLK(clk),
    .rst(rst),
`ifdef MULT_ACCUM_EN
    .mode_accum(mode_a),
`endif
    .m(a)
  );
  param_multiplier #(.IN_WIDTH(8), .DEPTH(4)) dut_b (
    .CLK(clk),
    .rst(rst),
`ifdef MULT_ACCUM_EN
    .mode_accum(mode_b),
`endif
    .m(b)
  );
  int checks = 0, failures = 0;
  int nvalid_a = 0, nread_a = 0, vbase = 0, nvalid_b = 0, idx_a = 0;
  logic vprev = 1'b0;
  logic [31:0] mem_a [64];
  logic [15:0] mem_b [4];
  logic [5:0] wqa[$], rqa[$];
  logic [31:0] wqv[$], rqv[$], blk[$];
  logic [15:0] rqb[$];
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  always @(posedge clk) begin
    if (a.EN_writeMem) mem_a[a.writeMem_addr] <= a.writeMem_val;
    if (a.EN_readMem) a.readMem_val <= mem_a[a.readMem_addr];
    if (b.EN_writeMem) mem_b[b.writeMem_addr] <= b.writeMem_val;
    if (b.EN_readMem) b.readMem_val <= mem_b[b.readMem_addr];
  end
  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_quiet_a", 64'({a.EN_writeMem, a.EN_readMem, a.VALID_memVal}), 64'(0));
      chk("rst_data_a", 64'(a.memVal_data), 64'(0));
    end else begin
      if (a.EN_writeMem) begin
        chk("write_expected", 64'(wqv.size() > 0), 64'(1));
        if (wqv.size() > 0) begin
          chk("write_addr", 64'(a.writeMem_addr), 64'(wqa.pop_front()));
          chk("write_val", 64'(a.writeMem_val), 64'(wqv.pop_front()));
        end
      end
      if (a.EN_readMem) begin
        nread_a++;
        chk("read_expected", 64'(rqa.size() > 0), 64'(1));
        if (rqa.size() > 0) chk("read_addr", 64'(a.readMem_addr), 64'(rqa.pop_front()));
      end
      if (a.VALID_memVal) begin
        nvalid_a++;
        chk("valid_expected", 64'(rqv.size() > 0), 64'(1));
        if (rqv.size() > 0) chk("mem_data", 64'(a.memVal_data), 64'(rqv.pop_front()));
      end
      if (vprev && !a.VALID_memVal) chk("rdy_after_drain", 64'(a.RDY_mult), 64'(1));
      if (b.VALID_memVal) begin
        nvalid_b++;
        chk("valid_expected_b", 64'(rqb.size() > 0), 64'(1));
        if (rqb.size() > 0) chk("mem_data_b", 64'(b.memVal_data), 64'(rqb.pop_front()));
      end
    end
    vprev = a.VALID_memVal;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic close_block();
    for (int i = 0; i < blk.size(); i++) begin
      rqa.push_back(6'(i));
      rqv.push_back(blk[i]);
    end
    blk.delete();
    idx_a = 0;
    vbase = nvalid_a;
  endtask
  task automatic accept_a(input logic [15:0] x, input logic [15:0] y, input logic close);
    a.EN_mult = 1'b1;
    a.mult_input0 = x;
    a.mult_input1 = y;
    a.EN_blockRead = close;
    wqa.push_back(6'(idx_a));
    wqv.push_back(32'(x) * 32'(y));
    blk.push_back(32'(x) * 32'(y));
    idx_a++;
    if (close) close_block();
    step();
    a.EN_mult = 1'b0;
    a.EN_blockRead = 1'b0;
  endtask
  task automatic block_read_a();
    a.EN_blockRead = 1'b1;
    close_block();
    step();
    a.EN_blockRead = 1'b0;
  endtask
  task automatic wait_a(input int n);
    for (int i = 0; i < 400 && nvalid_a - vbase < n; i++) step();
    repeat (3) step();
    chk("valid_count", 64'(nvalid_a - vbase), 64'(n));
    chk("read_queue_empty", 64'(rqv.size()), 64'(0));
  endtask
  task automatic accept_b(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    b.EN_mult = 1'b1;
    b.mult_input0 = x;
    b.mult_input1 = y;
    rqb.push_back(e);
    step();
    b.EN_mult = 1'b0;
  endtask
  task automatic run_b(input int n);
    int s;
    s = nvalid_b;
    chk("rdy_full_b", 64'(b.RDY_mult), 64'(0));
    b.EN_blockRead = 1'b1;
    step();
    b.EN_blockRead = 1'b0;
    repeat (20) step();
    chk("valid_count_b", 64'(nvalid_b - s), 64'(n));
  endtask
  initial begin
    int r;
    {a.EN_mult, a.EN_blockRead, a.mult_input0, a.mult_input1} = '0;
    {b.EN_mult, b.EN_blockRead, b.mult_input0, b.mult_input1} = '0;
    repeat (3) step();
    chk("rst_rdy_a", 64'(a.RDY_mult), 64'(0));
    chk("rst_rdy_b", 64'(b.RDY_mult), 64'(0));
    chk("rst_outs_b", 64'({b.EN_writeMem, b.EN_readMem, b.VALID_memVal}), 64'(0));
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(a.RDY_mult), 64'(1));
    accept_a(16'd6, 16'd4, 1'b0);
    for (int i = 0; i < 63; i++) accept_a(16'(i), 16'd2, 1'b0);
    chk("rdy_full", 64'(a.RDY_mult), 64'(0));
    block_read_a();
    wait_a(64);
    for (int i = 0; i < 10; i++) accept_a(16'(i + 1), 16'(1000 + i), i == 9);
    wait_a(10);
    r = nread_a;
    a.EN_blockRead = 1'b1;
    step();
    a.EN_blockRead = 1'b0;
    repeat (3) step();
    chk("idle_blockread_rdy", 64'(a.RDY_mult), 64'(1));
    chk("idle_blockread_noread", 64'(nread_a), 64'(r));
    for (int i = 0; i < 3; i++) accept_a(16'd7, 16'(i + 100), i == 2);
    for (int i = 0; i < 20 && !a.EN_readMem; i++) step();
    a.EN_mult = 1'b1;
    a.mult_input0 = 16'hffff;
    a.mult_input1 = 16'hffff;
    chk("rdy_in_read", 64'(a.RDY_mult), 64'(0));
    repeat (3) step();
    a.EN_mult = 1'b0;
    wait_a(3);
    for (int i = 0; i < 8; i++) accept_a(16'(i + 3), 16'd11, i == 7);
    for (int i = 0; i < 40 && !(a.EN_readMem && a.readMem_addr == 6'd4); i++) step();
    chk("fifth_read_addr", 64'(a.readMem_addr), 64'(4));
    rst = 1'b1;
    step();
    step();
    chk("valids_before_rst", 64'(nvalid_a - vbase), 64'(4));
    rqa.delete();
    rqv.delete();
    wqa.delete();
    wqv.delete();
    blk.delete();
    idx_a = 0;
    vbase = nvalid_a;
    rst = 1'b0;
    #1;
    chk("rdy_after_abort", 64'(a.RDY_mult), 64'(1));
    repeat (4) step();
    chk("no_valid_after_abort", 64'(nvalid_a), 64'(vbase));
    accept_a(16'd9, 16'd9, 1'b0);
    accept_a(16'd10, 16'd10, 1'b1);
    wait_a(2);
    for (int i = 0; i < 4; i++) accept_b(8'd255, 8'd255, 16'd65025);
    run_b(4);
`ifdef MULT_ACCUM_EN
    mode_b = 1'b1;
    accept_b(8'd3, 8'd1, 16'd3);
    accept_b(8'd3, 8'd2, 16'd9);
    accept_b(8'd3, 8'd3, 16'd18);
    accept_b(8'd3, 8'd4, 16'd30);
    run_b(4);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
